// File: rtl/result_core2fifo_pkg.sv
// Shared definitions for the core-to-result-FIFO stage: packed word layout and FSM states.
package result_core2fifo_pkg;

    localparam int unsigned FIELD_W_DEF = 32;

    // Packed word layout at the default field width: {t, u, v, hit}
    localparam int unsigned HIT_BIT = 0;
    localparam int unsigned V_LSB   = 1;
    localparam int unsigned U_LSB   = V_LSB + FIELD_W_DEF;
    localparam int unsigned T_LSB   = U_LSB + FIELD_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/result_skid_buf.sv
// Two-entry register buffer; input ready depends only on stored occupancy.
module result_skid_buf #(
    parameter int unsigned W = 97
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign in_ready_o  = (cnt_q < 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = head_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // The head register is left untouched when the buffer drains, so the
    // output keeps showing the last word written.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = in_data_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    tail_d = in_data_i;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = in_data_i;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/result_core2fifo.sv
// Accepts per-ray results from the intersection core, buffers them and writes
// them to the result FIFO, tracking progress against a host batch size.
module result_core2fifo
    import result_core2fifo_pkg::*;
#(
    parameter int unsigned FIELD_W = FIELD_W_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     batch_size,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic                 res_hit,
    input  logic [FIELD_W-1:0]   res_t,
    input  logic [FIELD_W-1:0]   res_u,
    input  logic [FIELD_W-1:0]   res_v,
    input  logic                 full,
    output logic [3*FIELD_W:0]   din,
    output logic                 write,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     written_count
);

    localparam int unsigned W    = 3 * FIELD_W + 1;
    localparam int unsigned U_LO = V_LSB + FIELD_W;
    localparam int unsigned T_LO = U_LO + FIELD_W;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] batch_q, batch_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] wr_q, wr_d;
    logic [W-1:0]     res_word;
    logic             buf_ready, buf_valid, accept;

    always_comb begin
        res_word                    = '0;
        res_word[HIT_BIT]           = res_hit;
        res_word[V_LSB +: FIELD_W]  = res_v;
        res_word[U_LO +: FIELD_W]   = res_u;
        res_word[T_LO +: FIELD_W]   = res_t;
    end

    assign res_ready     = (state_q == RUN) && buf_ready && (acc_q < batch_q);
    assign accept        = res_valid & res_ready;
    assign write         = buf_valid & ~full;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign written_count = wr_q;

    result_skid_buf #(
        .W (W)
    ) u_skid (
        .clk_i       (aclk),
        .rst_i       (areset),
        .in_valid_i  (accept),
        .in_data_i   (res_word),
        .in_ready_o  (buf_ready),
        .out_valid_o (buf_valid),
        .out_data_o  (din),
        .out_ready_i (~full)
    );

    always_comb begin
        state_d = state_q;
        batch_d = batch_q;
        acc_d   = acc_q;
        wr_d    = wr_q;
        case (state_q)
            RUN: begin
                if (accept) acc_d = acc_q + CNT_W'(1);
                if (write) begin
                    wr_d = wr_q + CNT_W'(1);
                    if (wr_d == batch_q) state_d = DONE;
                end
            end
            default: begin
                if (start) begin
                    batch_d = batch_size;
                    acc_d   = '0;
                    wr_d    = '0;
                    state_d = (batch_size == '0) ? DONE : RUN;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            batch_q <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            batch_q <= batch_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
        end
    end

endmodule
